// File: rtl/chan_pkg.sv
// Shared constants and types for the channel arbiter: control-word fields,
// word width and the arbiter state encoding.
package chan_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned CW_FLAG_BIT = 15;
  localparam int unsigned CW_CHAN_MSB = 14;
  localparam int unsigned CW_CHAN_LSB = 9;
  localparam int unsigned CW_LEN_MSB  = 8;
  localparam int unsigned CW_LEN_LSB  = 0;
  localparam int unsigned LEN_W       = CW_LEN_MSB - CW_LEN_LSB + 1;
  localparam int unsigned CNT_W       = 16;

  typedef enum logic {
    POLL = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  // Block length carried in a control word
  function automatic logic [LEN_W-1:0] cw_len(input logic [WORD_W-1:0] w);
    return w[CW_LEN_MSB:CW_LEN_LSB];
  endfunction

endpackage

// File: rtl/chan_arbiter_outreg.sv
// Single-entry output register; can_take_c says a new word may be loaded
// this cycle without overwriting an unaccepted one.
module arb_outreg
  import chan_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WORD_W-1:0] din,
  input  logic              dready,
  output logic [WORD_W-1:0] dout,
  output logic              dvalid,
  output logic              can_take_c
);

  assign can_take_c = ~dvalid | dready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout   <= '0;
      dvalid <= 1'b0;
    end else if (load) begin
      dout   <= din;
      dvalid <= 1'b1;
    end else if (dready) begin
      dvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/chan_arbiter.sv
// Round-robin block collector: polls channels with a one-hot give, forwards
// framed blocks to a single 16-bit stream, aborts stalled blocks by timeout.
module chan_arbiter
  import chan_pkg::*;
#(
  parameter int unsigned NCH   = 16,
  parameter int unsigned TBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NCH-1:0]        give,
  input  logic [NCH-1:0]        have,
  input  logic [WORD_W*NCH-1:0] din,
  output logic [WORD_W-1:0]     dout,
  output logic                  dvalid,
  input  logic                  dready,
  output logic                  blk_done,
  output logic                  err_cw,
  output logic                  err_tmo,
  output logic [CNT_W-1:0]      blk_cnt
);

  localparam int unsigned PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NCH - 1);
  // Last count before all-ones: the stall cycle that would reach it aborts
  localparam logic [TBITS-1:0] TMO_LAST = {{(TBITS-1){1'b1}}, 1'b0};

  arb_state_e        state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d, ptr_nxt;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [TBITS-1:0]  tmo_q, tmo_d;
  logic              done_d, cw_err_d, tmo_err_d;
  logic              load, can_take, give_en, take;
  logic [WORD_W-1:0] din_arr [NCH];
  logic [WORD_W-1:0] din_sel;

  for (genvar i = 0; i < NCH; i++) begin : g_din
    assign din_arr[i] = din[WORD_W*i +: WORD_W];
  end

  assign din_sel = din_arr[ptr_q];
  assign give_en = can_take & ~rst;
  assign give    = give_en ? (NCH'(1) << ptr_q) : '0;
  assign take    = give_en & have[ptr_q];
  assign ptr_nxt = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);

  arb_outreg u_outreg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .din        (din_sel),
    .dready     (dready),
    .dout       (dout),
    .dvalid     (dvalid),
    .can_take_c (can_take)
  );

  // Next-state, pointer, length and timeout logic
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    remain_d  = remain_q;
    tmo_d     = tmo_q;
    load      = 1'b0;
    done_d    = 1'b0;
    cw_err_d  = 1'b0;
    tmo_err_d = 1'b0;
    case (state_q)
      POLL: begin
        if (take) begin
          if (din_sel[CW_FLAG_BIT]) begin
            load     = 1'b1;
            remain_d = cw_len(din_sel);
            tmo_d    = '0;
            if (cw_len(din_sel) == '0) begin
              done_d = 1'b1;
              ptr_d  = ptr_nxt;
            end else begin
              state_d = XFER;
            end
          end else begin
            cw_err_d = 1'b1;
            ptr_d    = ptr_nxt;
          end
        end else if (give_en) begin
          ptr_d = ptr_nxt;
        end
      end
      XFER: begin
        if (take) begin
          load     = 1'b1;
          tmo_d    = '0;
          remain_d = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            ptr_d   = ptr_nxt;
            state_d = POLL;
          end
        end else if (give_en) begin
          if (tmo_q == TMO_LAST) begin
            tmo_err_d = 1'b1;
            tmo_d     = '0;
            remain_d  = '0;
            ptr_d     = ptr_nxt;
            state_d   = POLL;
          end else begin
            tmo_d = tmo_q + TBITS'(1);
          end
        end
      end
      default: state_d = POLL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= POLL;
      ptr_q    <= '0;
      remain_q <= '0;
      tmo_q    <= '0;
      blk_done <= 1'b0;
      err_cw   <= 1'b0;
      err_tmo  <= 1'b0;
      blk_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      remain_q <= remain_d;
      tmo_q    <= tmo_d;
      blk_done <= done_d;
      err_cw   <= cw_err_d;
      err_tmo  <= tmo_err_d;
      if (done_d) blk_cnt <= blk_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_chan_arbiter.sv
// Scoreboard bench for chan_arbiter: channel models hold word FIFOs, a
// negedge monitor checks the output stream against queued expectations.
module tb_chan_arbiter;

  localparam int unsigned NCH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NCH-1:0]  give;
  logic [NCH-1:0]  have;
  logic [16*NCH-1:0] din;
  logic [15:0]     dout;
  logic            dvalid;
  logic            dready = 1'b1;
  logic            blk_done, err_cw, err_tmo;
  logic [15:0]     blk_cnt;

  logic [15:0]     mem [NCH][16];
  int unsigned     wr_idx [NCH];
  int unsigned     rd_idx [NCH];
  logic [15:0]     exp_q [$];

  int checks = 0;
  int errors = 0;
  int n_done = 0, n_cw = 0, n_tmo = 0;

  always #4 clk = ~clk;

  chan_arbiter #(.NCH(NCH), .TBITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .give     (give),
    .have     (have),
    .din      (din),
    .dout     (dout),
    .dvalid   (dvalid),
    .dready   (dready),
    .blk_done (blk_done),
    .err_cw   (err_cw),
    .err_tmo  (err_tmo),
    .blk_cnt  (blk_cnt)
  );

  // Channel processors: acknowledge give while words remain
  always_comb begin
    have = '0;
    din  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_idx[i] < wr_idx[i]) begin
        have[i] = give[i];
        din[16*i +: 16] = mem[i][4'(rd_idx[i])];
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst) rd_idx[i] <= 0;
      else if (give[i] && have[i]) rd_idx[i] <= rd_idx[i] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop expected words on each accepted output
  always @(negedge clk) begin
    if (!rst) begin
      if (dvalid && dready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, expected no output (t=%0t)", dout, $time);
        end else begin
          check("dout", 32'(dout), 32'(exp_q.pop_front()));
        end
      end
      if (dvalid && !dready) check("give_under_backpressure", 32'(give), 32'h0);
      check("give_onehot0", 32'($onehot0(give)), 32'h1);
      n_done += int'(blk_done);
      n_cw   += int'(err_cw);
      n_tmo  += int'(err_tmo);
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic load(input int ch, input logic [15:0] w, input bit emitted);
    mem[ch][4'(wr_idx[ch])] = w;
    wr_idx[ch]++;
    if (emitted) exp_q.push_back(w);
  endtask

  task automatic start_test();
    tick();
    rst = 1'b1;
    dready = 1'b1;
    for (int i = 0; i < NCH; i++) wr_idx[i] = 0;
    tick();
    tick();
  endtask

  task automatic release_rst();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (exp_q.size() == 0 && !dvalid) break;
      tick();
    end
    check("drain_remaining", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    logic [3:0] give_seq [9];
    logic       rdy_pat [4];
    int d0, c0, t0, stall;
    bit seen;

    for (int i = 0; i < NCH; i++) wr_idx[i] = 0;
    tick();
    check("reset_give", 32'(give), 32'h0);
    check("reset_dvalid", 32'(dvalid), 32'h0);
    check("reset_dout", 32'(dout), 32'h0);
    check("reset_blk_cnt", 32'(blk_cnt), 32'h0);
    check("reset_pulses", 32'({blk_done, err_cw, err_tmo}), 32'h0);

    // Single block on channel 2
    start_test();
    load(2, 16'h8405, 1'b1);
    for (int k = 1; k <= 5; k++) load(2, 16'(k), 1'b1);
    give_seq = '{4'h1, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h8};
    d0 = n_done;
    release_rst();
    for (int k = 0; k < 9; k++) begin
      check($sformatf("t1_give_%0d", k), 32'(give), 32'(give_seq[k]));
      if (blk_done) check("t1_done_with_last_word", 32'({dvalid, dout}), 32'h1_0005);
      tick();
    end
    wait_drain(20);
    check("t1_blk_done_count", 32'(n_done - d0), 32'd1);
    check("t1_blk_cnt", 32'(blk_cnt), 32'd1);

    // Two back-to-back blocks, channel 0 then channel 1
    start_test();
    load(0, 16'h8003, 1'b1);
    load(0, 16'h00A1, 1'b1); load(0, 16'h00A2, 1'b1); load(0, 16'h00A3, 1'b1);
    load(1, 16'h8203, 1'b1);
    load(1, 16'h00B1, 1'b1); load(1, 16'h00B2, 1'b1); load(1, 16'h00B3, 1'b1);
    release_rst();
    wait_drain(60);
    check("t2_blk_cnt", 32'(blk_cnt), 32'd2);

    // Back-pressure inside a block
    start_test();
    load(0, 16'h8004, 1'b1);
    for (int k = 1; k <= 4; k++) load(0, 16'hC000 | 16'(k), 1'b1);
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    d0 = n_done; t0 = n_tmo;
    release_rst();
    tick();
    for (int k = 0; k < 4; k++) begin
      dready = rdy_pat[k];
      tick();
    end
    dready = 1'b1;
    wait_drain(40);
    check("t3_blk_done_count", 32'(n_done - d0), 32'd1);
    check("t3_no_timeout", 32'(n_tmo - t0), 32'd0);

    // Desync word on channel 1, empty block on channel 2
    start_test();
    load(1, 16'h1234, 1'b0);
    load(2, 16'h8400, 1'b1);
    c0 = n_cw; d0 = n_done;
    release_rst();
    check("t4_give_0", 32'(give), 32'h1);
    tick();
    check("t4_give_1", 32'(give), 32'h2);
    tick();
    check("t4_next_poll", 32'(give), 32'h4);
    check("t4_err_cw_pulse", 32'({err_cw, dvalid}), 32'h2);
    wait_drain(20);
    check("t4_err_cw_count", 32'(n_cw - c0), 32'd1);
    check("t4_empty_block_done", 32'(n_done - d0), 32'd1);

    // Stalled block aborted by timeout
    start_test();
    load(0, 16'h800A, 1'b1);
    load(0, 16'h0D01, 1'b1); load(0, 16'h0D02, 1'b1); load(0, 16'h0D03, 1'b1);
    d0 = n_done; t0 = n_tmo; stall = 0; seen = 1'b0;
    release_rst();
    for (int k = 0; k < 400; k++) begin
      if (err_tmo) begin
        seen = 1'b1;
        break;
      end
      if (give[0] && !have[0]) stall++;
      tick();
    end
    check("t5_timeout_seen", 32'(seen), 32'h1);
    check("t5_stall_cycles", 32'(stall), 32'd255);
    check("t5_next_poll", 32'(give), 32'h2);
    wait_drain(20);
    check("t5_err_tmo_count", 32'(n_tmo - t0), 32'd1);
    check("t5_no_blk_done", 32'(n_done - d0), 32'd0);
    check("t5_blk_cnt", 32'(blk_cnt), 32'd0);

    // Reset in the middle of a block
    start_test();
    load(0, 16'h800A, 1'b0);
    for (int k = 1; k <= 10; k++) load(0, 16'h0E00 | 16'(k), 1'b0);
    exp_q.push_back(16'h800A);
    exp_q.push_back(16'h0E01);
    exp_q.push_back(16'h0E02);
    release_rst();
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_reset_give", 32'(give), 32'h0);
    check("t6_reset_dvalid", 32'(dvalid), 32'h0);
    check("t6_words_before_reset", 32'(exp_q.size()), 32'h0);
    for (int i = 0; i < NCH; i++) wr_idx[i] = 0;
    tick();
    load(1, 16'h8201, 1'b1);
    load(1, 16'h00F1, 1'b1);
    release_rst();
    check("t6_restart_ch0", 32'(give), 32'h1);
    tick();
    check("t6_then_ch1", 32'(give), 32'h2);
    wait_drain(20);
    check("t6_blk_cnt", 32'(blk_cnt), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before limit");
    $fatal(1);
  end

endmodule
